mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the processor's instruction-fetch requester and its load/store requester.
- Sits between the processor core's instruction/data IO and a single-ported memory or bus bridge.
- Sequences one transaction at a time with a registered request/ready handshake.
- Data accesses have priority; a starvation guard guarantees instruction-fetch progress.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; mask width is DATA_W/8
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending; valid range 1-15

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ip_inst_req  input  1  fetch request; held until op_inst_valid
ip_inst_addr  input  ADDR_W  fetch address, stable while ip_inst_req high
op_inst_valid  output  1  one-cycle pulse: fetch complete
op_inst_data  output  DATA_W  fetched word, valid with op_inst_valid
ip_data_rd  input  1  load request; held until op_data_valid
ip_data_wr  input  1  store request; held until op_data_valid
ip_data_addr  input  ADDR_W  load/store address
ip_data_mask  input  DATA_W/8  byte enables
ip_data_wdata  input  DATA_W  store data
op_data_valid  output  1  one-cycle pulse: load/store complete
op_data_rdata  output  DATA_W  load data; 0 for stores
op_mem_req  output  1  memory request, held until op_mem_ready is sampled high
op_mem_we  output  1  1 = write
op_mem_addr  output  ADDR_W  memory address
op_mem_mask  output  DATA_W/8  memory byte enables
op_mem_wdata  output  DATA_W  memory write data
ip_mem_ready  input  1  memory accepted/completed the access this cycle
ip_mem_rdata  input  DATA_W  read data, valid with ip_mem_ready
op_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset:
  - state = IDLE; starvation counter = 0.
  - All outputs are 0, including op_mem_* and the op_*_data buses.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Stay in IDLE while no request is pending.
  - On a pending request, select a winner and register op_mem_we, op_mem_addr, op_mem_mask and op_mem_wdata.
  - Set op_mem_req = 1 and move to ISSUE.
- Winner selection:
  - A data request (ip_data_rd | ip_data_wr) wins over ip_inst_req.
  - Exception: inst wins when ip_inst_req is high and starve_cnt == STARVE_LIMIT.
- Starvation counter:
  - Increments on a data grant while ip_inst_req is high.
  - Clears on any inst grant.
  - Clears on a data grant while ip_inst_req is low.
  - Saturates at STARVE_LIMIT.
- Instruction grant: we = 0, mask = all ones, wdata = 0.
- ip_data_wr and ip_data_rd both high: treated as a write; rd is ignored.
- ISSUE:
  - op_mem_req and all op_mem_* outputs are held stable.
  - On ip_mem_ready = 1:
    - Capture ip_mem_rdata into the winner's data output. Stores return 0.
    - Drop op_mem_req in the next cycle.
    - Move to RESP.
  - No timeout; ISSUE waits indefinitely.
- RESP:
  - The winner's op_*_valid is high for exactly this one cycle. The other requester's valid stays 0.
  - Next state is always IDLE.
  - op_*_data holds its value until overwritten by that requester's next completion.
- Requester obligation: deassert the request, or present a new one, by the cycle after valid.
  - A request sampled in IDLE is always treated as new.
- Latency:
  - Request seen in IDLE at cycle N → op_mem_req high at N+1.
  - ip_mem_ready at N+1 → valid at N+2. This is the minimum 3-cycle occupancy.
  - Each extra ready-wait cycle adds 1.
- ip_mem_ready while not in ISSUE is ignored.
- Requests changing mid-transaction do not affect the in-flight access, because its fields are registered at grant.
- Reset mid-operation:
  - The transaction is abandoned; op_mem_req = 0 in the cycle after reset is sampled.
  - No valid pulse is produced; the counter is cleared.
  - The memory side must tolerate a dropped request.
- op_busy = (state != IDLE).

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE/ISSUE/RESP, 2 bits)
  - grant-source encoding (GNT_INST/GNT_DATA)
  - default STARVE_LIMIT constant
- One natural sub-module, mem_arb_select: winner choice plus starvation counter, with clk/reset.
- Everything else (FSM, request registers, response capture) stays in mem_port_arbiter.

Test Plan:
- Single fetch: ip_inst_req = 1, addr 0x100, ready returned the first ISSUE cycle with rdata 0x00500093 → op_mem_req at N+1 with we = 0, mask = 0xF; op_inst_valid at N+2 with op_inst_data = 0x00500093.
- Simultaneous fetch and load, addresses 0x200 / 0x8000 → data granted first, op_data_valid with load data; inst granted next IDLE and op_inst_valid 3 cycles later.
- Starvation: data requests continuous, inst held, STARVE_LIMIT = 4 → exactly 4 data grants, then 1 inst grant, then data resumes.
- Store with wait states: wr = 1, addr 0x40, mask 0x3, wdata 0xDEADBEEF, ready delayed 5 cycles → op_mem_* stable all 6 ISSUE cycles; op_data_valid once with op_data_rdata = 0.
- Reset mid-ISSUE: assert reset for 1 cycle during ISSUE → op_mem_req = 0 next cycle; no valid pulse; state IDLE; a following fetch completes in 3 cycles.
- rd + wr both high with stray ip_mem_ready in IDLE → stray ready ignored; a write is issued (we = 1); exactly one op_data_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Holds the FSM state encoding, the grant-source encoding and the default
// starvation limit used by mem_port_arbiter and mem_arb_select.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_t;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  // Counter width covers the legal STARVE_LIMIT range 1..15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side bus of the memory port arbiter.
// slave  : arbiter view (takes fetch/load/store requests and memory responses,
//          drives completions and the memory request).
// master : environment view (core requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              ip_inst_req;
  logic [ADDR_W-1:0] ip_inst_addr;
  logic              op_inst_valid;
  logic [DATA_W-1:0] op_inst_data;

  logic              ip_data_rd;
  logic              ip_data_wr;
  logic [ADDR_W-1:0] ip_data_addr;
  logic [MASK_W-1:0] ip_data_mask;
  logic [DATA_W-1:0] ip_data_wdata;
  logic              op_data_valid;
  logic [DATA_W-1:0] op_data_rdata;

  logic              op_mem_req;
  logic              op_mem_we;
  logic [ADDR_W-1:0] op_mem_addr;
  logic [MASK_W-1:0] op_mem_mask;
  logic [DATA_W-1:0] op_mem_wdata;
  logic              ip_mem_ready;
  logic [DATA_W-1:0] ip_mem_rdata;

  logic              op_busy;

  modport slave (
    input  ip_inst_req, ip_inst_addr,
    input  ip_data_rd, ip_data_wr, ip_data_addr, ip_data_mask, ip_data_wdata,
    input  ip_mem_ready, ip_mem_rdata,
    output op_inst_valid, op_inst_data,
    output op_data_valid, op_data_rdata,
    output op_mem_req, op_mem_we, op_mem_addr, op_mem_mask, op_mem_wdata,
    output op_busy
  );

  modport master (
    output ip_inst_req, ip_inst_addr,
    output ip_data_rd, ip_data_wr, ip_data_addr, ip_data_mask, ip_data_wdata,
    output ip_mem_ready, ip_mem_rdata,
    input  op_inst_valid, op_inst_data,
    input  op_data_valid, op_data_rdata,
    input  op_mem_req, op_mem_we, op_mem_addr, op_mem_mask, op_mem_wdata,
    input  op_busy
  );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection and starvation counter for the memory port arbiter.
// Ports: clk, reset (sync, active-high), inst_req/data_req (pending requests),
//        grant (a winner is being latched this cycle), gnt_src_c (combinational
//        winner for the current request set).
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant,
  output gnt_t gnt_src_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Data has priority unless a pending fetch has been passed over LIMIT times
  assign gnt_src_c = (inst_req && (!data_req || (starve_cnt == LIMIT))) ? GNT_INST : GNT_DATA;

  // Counts consecutive data grants taken while a fetch was waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if ((gnt_src_c == GNT_DATA) && inst_req) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
// One transaction at a time: IDLE grants and registers the access, ISSUE holds
// op_mem_* until ip_mem_ready, RESP pulses the winner's valid for one cycle.
// Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave)
//        carrying fetch, load/store, memory and busy signals.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned MASK_W = DATA_W / 8;

  state_t            state_q, state_d;
  gnt_t              gnt_src_c, owner_q;
  logic              data_req_c, any_req_c, grant_c, done_c;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [MASK_W-1:0] mem_mask_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              inst_valid_q, data_valid_q, busy_q;
  logic [DATA_W-1:0] inst_data_q, data_rdata_q;

  assign data_req_c = bus.ip_data_rd | bus.ip_data_wr;
  assign any_req_c  = data_req_c | bus.ip_inst_req;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .clk       (clk),
    .reset     (reset),
    .inst_req  (bus.ip_inst_req),
    .data_req  (data_req_c),
    .grant     (grant_c),
    .gnt_src_c (gnt_src_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus grant / completion strobes
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          grant_c = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.ip_mem_ready) begin
          done_c  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory request registers, response capture and valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= GNT_INST;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_mask_q   <= '0;
      mem_wdata_q  <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= (state_d != ST_IDLE);
      if (grant_c) begin
        mem_req_q <= 1'b1;
        owner_q   <= gnt_src_c;
        if (gnt_src_c == GNT_INST) begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.ip_inst_addr;
          mem_mask_q  <= '1;
          mem_wdata_q <= '0;
        end else begin
          // rd+wr together resolves to a write
          mem_we_q    <= bus.ip_data_wr;
          mem_addr_q  <= bus.ip_data_addr;
          mem_mask_q  <= bus.ip_data_mask;
          mem_wdata_q <= bus.ip_data_wdata;
        end
      end
      if (done_c) begin
        mem_req_q <= 1'b0;
        if (owner_q == GNT_INST) begin
          inst_valid_q <= 1'b1;
          inst_data_q  <= bus.ip_mem_rdata;
        end else begin
          data_valid_q <= 1'b1;
          data_rdata_q <= mem_we_q ? DATA_W'(0) : bus.ip_mem_rdata;
        end
      end
    end
  end

  assign bus.op_mem_req    = mem_req_q;
  assign bus.op_mem_we     = mem_we_q;
  assign bus.op_mem_addr   = mem_addr_q;
  assign bus.op_mem_mask   = mem_mask_q;
  assign bus.op_mem_wdata  = mem_wdata_q;
  assign bus.op_inst_valid = inst_valid_q;
  assign bus.op_inst_data  = inst_data_q;
  assign bus.op_data_valid = data_valid_q;
  assign bus.op_data_rdata = data_rdata_q;
  assign bus.op_busy       = busy_q;

endmodule
